// File: rtl/kmeans_iter_ctrl.sv
// Iteration sequencer for the k-means core: streams RAM samples into the datapath once per pass,
// requests a centroid update, and repeats until convergence or MAX_ITER passes, then interrupts.
module kmeans_iter_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int RAM_LAT  = 1,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              dp_clear,
    output logic              dp_point_valid,
    output logic              dp_update,
    input  logic              dp_update_done,
    input  logic              dp_converged,
    output logic              busy,
    output logic              interupt,
    output logic [ITER_W-1:0] iter_count,
    output logic [1:0]        status
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_SCAN     = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_UPDATE   = 3'd4;
    localparam logic [2:0] S_WAIT_UPD = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    logic [2:0]        state_q, state_d;
    logic              go_q;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  drain_q, drain_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [1:0]        status_q, status_d;
    logic [RAM_LAT-1:0] pipe_q;
    logic              start;

    assign start = go & ~go_q & (state_q == S_IDLE);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
        iter_d   = iter_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    first_d  = first_addr;
                    last_d   = last_addr;
                    iter_d   = '0;
                    status_d = 2'b00;
                    if (first_addr > last_addr) begin
                        status_d = 2'b11;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                addr_d  = first_q;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // Compare before incrementing so a range ending at the top address never wraps.
                if (addr_q == last_q) begin
                    drain_d = LAT_W'(RAM_LAT - 1);
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_UPDATE;
                else               drain_d = drain_q - LAT_W'(1);
            end
            S_UPDATE: begin
                iter_d  = iter_q + ITER_W'(1);
                state_d = S_WAIT_UPD;
            end
            S_WAIT_UPD: begin
                if (dp_update_done) begin
                    if (dp_converged) begin
                        status_d = 2'b01;
                        state_d  = S_DONE;
                    end else if (iter_q == ITER_W'(MAX_ITER)) begin
                        status_d = 2'b10;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CLEAR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            go_q     <= 1'b0;
            first_q  <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            drain_q  <= '0;
            iter_q   <= '0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            go_q     <= go;
            first_q  <= first_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            iter_q   <= iter_d;
            status_q <= status_d;
        end
    end

    // Point-valid is the read strobe delayed by exactly the RAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= ram_rd_en;
            for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign ram_rd_en      = (state_q == S_SCAN);
    assign ram_addr       = addr_q;
    assign dp_clear       = (state_q == S_CLEAR);
    assign dp_point_valid = pipe_q[RAM_LAT-1];
    assign dp_update      = (state_q == S_UPDATE);
    assign busy           = (state_q == S_CLEAR) || (state_q == S_SCAN) || (state_q == S_DRAIN) ||
                            (state_q == S_UPDATE) || (state_q == S_WAIT_UPD);
    assign interupt       = (state_q == S_DONE);
    assign iter_count     = iter_q;
    assign status         = status_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl (defaults: ADDR_W=9, RAM_LAT=1, MAX_ITER=16) with a
// cycle-stepped loop that plays the datapath and tallies every observable event per run.
module tb_kmeans_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic [8:0] first_addr = '0;
    logic [8:0] last_addr = '0;
    logic       dp_update_done = 1'b0;
    logic       dp_converged = 1'b0;
    logic       ram_rd_en, dp_clear, dp_point_valid, dp_update, busy, interupt;
    logic [8:0] ram_addr;
    logic [4:0] iter_count;
    logic [1:0] status;

    kmeans_iter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .go(go), .first_addr(first_addr), .last_addr(last_addr),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .dp_clear(dp_clear),
        .dp_point_valid(dp_point_valid), .dp_update(dp_update), .dp_update_done(dp_update_done),
        .dp_converged(dp_converged), .busy(busy), .interupt(interupt),
        .iter_count(iter_count), .status(status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int n_rd, n_valid, n_clr, n_upd, n_int, n_busy, lag_err;
    int first_rd_cyc, upd_cyc, int_cyc;
    bit saw_zero, int_seen;
    int rd_list[$];

    function automatic logic [31:0] all_outputs();
        return 32'({ram_rd_en, ram_addr, dp_clear, dp_point_valid, dp_update, busy, interupt,
                    iter_count, status});
    endfunction

    // Starts a run and steps it cycle by cycle; cycle 1 is the first sample after the start edge.
    task automatic run(input logic [8:0] f, input logic [8:0] l, input bit conv, input int max_cyc,
                       input int go_lo1, input int go_hi, input int go_lo2, input int inj_cyc,
                       input int rst_at);
        int  cyc = 0;
        int  post = 0;
        int  timer = 0;
        bit  prev_rd = 1'b0;
        n_rd = 0; n_valid = 0; n_clr = 0; n_upd = 0; n_int = 0; n_busy = 0; lag_err = 0;
        first_rd_cyc = -1; upd_cyc = -1; int_cyc = -1; saw_zero = 1'b0; int_seen = 1'b0;
        rd_list.delete();
        first_addr = f;
        last_addr  = l;
        go = 1'b1;
        while (!(int_seen && post >= 3) && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_mid_scan_outputs", all_outputs(), 32'd0);
                return;
            end
            if (ram_rd_en) begin
                n_rd++;
                rd_list.push_back(int'(ram_addr));
                if (ram_addr == 9'd0) saw_zero = 1'b1;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (dp_point_valid) n_valid++;
            if (dp_point_valid !== prev_rd) lag_err++;
            prev_rd = ram_rd_en;
            if (dp_clear) n_clr++;
            if (dp_update) begin
                n_upd++;
                if (upd_cyc < 0) upd_cyc = cyc;
            end
            if (busy) n_busy++;
            if (int_seen) post++;
            if (interupt) begin
                n_int++;
                if (!int_seen) int_cyc = cyc;
                int_seen = 1'b1;
            end
            // Datapath model: done (with the convergence flag) two cycles after the update pulse.
            dp_update_done = 1'b0;
            dp_converged   = 1'b0;
            if (dp_update) timer = 2;
            else if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    dp_update_done = 1'b1;
                    dp_converged   = conv;
                end
            end
            if (cyc == inj_cyc) begin
                dp_update_done = 1'b1;
                dp_converged   = 1'b1;
            end
            if (cyc == go_lo1 || cyc == go_lo2) go = 1'b0;
            if (cyc == go_hi) go = 1'b1;
        end
        check("run_completed", 32'(int_seen), 32'd1);
        go = 1'b0;
        dp_update_done = 1'b0;
        dp_converged = 1'b0;
        @(posedge clk); #1;
    endtask

    // Expected results of a 0..3 range converging on the first update with RAM_LAT=1.
    task automatic check_basic(input string p);
        check({p, "_reads"}, 32'(n_rd), 32'd4);
        for (int i = 0; i < 4; i++)
            check({p, "_addr"}, (i < rd_list.size()) ? 32'(rd_list[i]) : 32'hFFFF, 32'(i));
        check({p, "_valid_count"}, 32'(n_valid), 32'd4);
        check({p, "_valid_lag"}, 32'(lag_err), 32'd0);
        check({p, "_clears"}, 32'(n_clr), 32'd1);
        check({p, "_updates"}, 32'(n_upd), 32'd1);
        check({p, "_first_read_cycle"}, 32'(first_rd_cyc), 32'd2);
        check({p, "_update_cycle"}, 32'(upd_cyc), 32'd7);
        check({p, "_busy_cycles"}, 32'(n_busy), 32'd9);
        check({p, "_interrupts"}, 32'(n_int), 32'd1);
        check({p, "_status"}, 32'(status), 32'd1);
        check({p, "_iter_count"}, 32'(iter_count), 32'd1);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: short range, converges on the first pass
        run(9'd0, 9'd3, 1'b1, 100, -1, -1, -1, -1, -1);
        check_basic("t1");

        // 2: never converges, stops after MAX_ITER passes
        run(9'd2, 9'd4, 1'b0, 400, -1, -1, -1, -1, -1);
        check("t2_clears", 32'(n_clr), 32'd16);
        check("t2_updates", 32'(n_upd), 32'd16);
        check("t2_reads", 32'(n_rd), 32'd48);
        check("t2_interrupts", 32'(n_int), 32'd1);
        check("t2_status", 32'(status), 32'd2);
        check("t2_iter_count", 32'(iter_count), 32'd16);
        check("t2_valid_lag", 32'(lag_err), 32'd0);

        // 3a: inverted range, no reads at all
        run(9'd6, 9'd5, 1'b1, 50, -1, -1, -1, -1, -1);
        check("t3a_reads", 32'(n_rd), 32'd0);
        check("t3a_clears", 32'(n_clr), 32'd0);
        check("t3a_busy", 32'(n_busy), 32'd0);
        check("t3a_int_cycle", 32'(int_cyc), 32'd1);
        check("t3a_interrupts", 32'(n_int), 32'd1);
        check("t3a_status", 32'(status), 32'd3);
        check("t3a_iter_count", 32'(iter_count), 32'd0);

        // 3b: single-sample range
        run(9'd5, 9'd5, 1'b1, 50, -1, -1, -1, -1, -1);
        check("t3b_reads", 32'(n_rd), 32'd1);
        check("t3b_addr", (rd_list.size() > 0) ? 32'(rd_list[0]) : 32'hFFFF, 32'd5);
        check("t3b_update_cycle", 32'(upd_cyc), 32'd4);
        check("t3b_status", 32'(status), 32'd1);

        // 4: range touching the top address must not wrap
        run(9'd510, 9'd511, 1'b1, 50, -1, -1, -1, -1, -1);
        check("t4_reads", 32'(n_rd), 32'd2);
        check("t4_addr0", (rd_list.size() > 0) ? 32'(rd_list[0]) : 32'hFFFF, 32'd510);
        check("t4_addr1", (rd_list.size() > 1) ? 32'(rd_list[1]) : 32'hFFFF, 32'd511);
        check("t4_saw_zero", 32'(saw_zero), 32'd0);
        check("t4_valid_count", 32'(n_valid), 32'd2);
        check("t4_update_cycle", 32'(upd_cyc), 32'd5);
        check("t4_addr_hold", 32'(ram_addr), 32'd511);

        // 5: go bounced and spurious done during SCAN, go dropped mid-run
        run(9'd0, 9'd3, 1'b1, 100, 2, 3, 6, 4, -1);
        check_basic("t5");

        // 6: reset during SCAN of the second pass, then a clean rerun
        run(9'd0, 9'd3, 1'b0, 200, -1, -1, -1, -1, 12);
        go = 1'b0;
        k = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (interupt) k++;
        end
        check("t6_no_int_in_reset", 32'(k), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(9'd0, 9'd3, 1'b1, 100, -1, -1, -1, -1, -1);
        check_basic("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
